// File: rtl/ex_stage_pkg.sv
// ex_stage_pkg
//   Shared definitions for the execute stage of the 4-thread barrel pipeline:
//   ALU func3 encodings, thread geometry, and the width and saturating
//   increment used by the per-thread useful-instruction counters.
package ex_stage_pkg;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SLL  = 3'b001;
  localparam logic [2:0] ALU_SLT  = 3'b010;
  localparam logic [2:0] ALU_SLTU = 3'b011;
  localparam logic [2:0] ALU_XOR  = 3'b100;
  localparam logic [2:0] ALU_SRL  = 3'b101;
  localparam logic [2:0] ALU_OR   = 3'b110;
  localparam logic [2:0] ALU_AND  = 3'b111;

  localparam int NUM_THREADS     = 4;
  localparam int THREAD_ID_WIDTH = $clog2(NUM_THREADS);
  localparam int COUNTER_WIDTH   = 16;

  // Counters stick at all-ones instead of wrapping.
  function automatic logic [COUNTER_WIDTH-1:0] sat_inc(input logic [COUNTER_WIDTH-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/ex_alu.sv
// ex_alu
//   Purely combinational ALU of the execute stage.
//   Ports:
//     a, b      : operands (b already muxed between register and immediate)
//     func3     : operation select (ALU_* encodings)
//     func7     : arithmetic-shift select for the right shift
//     sub_en    : turns the func3=000 add into a subtract
//     addr_mode : forces a+b for load/store address generation
//     result    : operation result
module ex_alu
  import ex_stage_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       func3,
  input  logic             func7,
  input  logic             sub_en,
  input  logic             addr_mode,
  output logic [WIDTH-1:0] result
);

  logic [3:0] shamt;
  logic       lt_signed;
  logic       lt_unsigned;

  assign shamt       = b[3:0];
  assign lt_signed   = $signed(a) < $signed(b);
  assign lt_unsigned = a < b;

  always_comb begin
    result = '0;
    if (addr_mode) begin
      result = a + b;
    end else begin
      unique case (func3)
        ALU_ADD:  result = sub_en ? (a - b) : (a + b);
        ALU_SLL:  result = a << shamt;
        ALU_SLT:  result = {{(WIDTH-1){1'b0}}, lt_signed};
        ALU_SLTU: result = {{(WIDTH-1){1'b0}}, lt_unsigned};
        ALU_XOR:  result = a ^ b;
        ALU_SRL:  result = func7 ? WIDTH'($signed(a) >>> shamt) : (a >> shamt);
        ALU_OR:   result = a | b;
        ALU_AND:  result = a & b;
        default:  result = '0;
      endcase
    end
  end

endmodule

// File: rtl/ex_stage.sv
// ex_stage
//   Execute stage: picks operand B, runs the ALU (or address adder), and
//   registers result plus forwarded control into the EX/MEM outputs with a
//   single cycle of latency. Also keeps one saturating counter per thread of
//   useful instructions, exposed through a registered debug read port.
//   Ports:
//     CLK, RST                     : clock, synchronous active-high reset
//     *_in, pc_carry_baggage_i     : ID/EX pipeline register contents
//     alu_result_o, store_data_o   : ALU result / address, store data
//     WRegEn_o .. pc_carry_baggage_o : forwarded control and tags
//     cnt_clr_i                    : clear all counters
//     cnt_rd_thread_i, cnt_rd_data_o : counter select and registered value
module ex_stage
  import ex_stage_pkg::*;
#(
  parameter int PROC_DATA_WIDTH        = 16,
  parameter int PROC_REGFILE_LOG2_DEEP = 5,
  parameter int INSTMEM_LOG2_DEEP      = 8
) (
  input  logic                              CLK,
  input  logic                              RST,
  input  logic                              WRegEn_in,
  input  logic                              WMemEn_in,
  input  logic                              alu_src_in,
  input  logic                              mem_to_reg_in,
  input  logic [PROC_DATA_WIDTH-1:0]        R1out_in,
  input  logic [PROC_DATA_WIDTH-1:0]        R2out_in,
  input  logic [PROC_DATA_WIDTH-1:0]        sign_ext_in,
  input  logic [PROC_REGFILE_LOG2_DEEP-1:0] WReg1_in,
  input  logic [2:0]                        func3_in,
  input  logic                              func7_in,
  input  logic [THREAD_ID_WIDTH-1:0]        thread_id_in,
  input  logic [INSTMEM_LOG2_DEEP-1:0]      pc_carry_baggage_i,
  output logic [PROC_DATA_WIDTH-1:0]        alu_result_o,
  output logic [PROC_DATA_WIDTH-1:0]        store_data_o,
  output logic                              WRegEn_o,
  output logic                              WMemEn_o,
  output logic                              mem_to_reg_o,
  output logic [PROC_REGFILE_LOG2_DEEP-1:0] WReg1_o,
  output logic [THREAD_ID_WIDTH-1:0]        thread_id_o,
  output logic [INSTMEM_LOG2_DEEP-1:0]      pc_carry_baggage_o,
  input  logic                              cnt_clr_i,
  input  logic [THREAD_ID_WIDTH-1:0]        cnt_rd_thread_i,
  output logic [COUNTER_WIDTH-1:0]          cnt_rd_data_o
);

  logic [PROC_DATA_WIDTH-1:0] op_b;
  logic [PROC_DATA_WIDTH-1:0] alu_result;
  logic                       sub_en;
  logic                       addr_mode;
  logic                       wreg_eff;
  logic                       useful;

  logic [COUNTER_WIDTH-1:0] cnt_q [NUM_THREADS];

  assign op_b      = alu_src_in ? sign_ext_in : R2out_in;
  // Immediate forms have no subtract; func7 only means sub for R-type.
  assign sub_en    = func7_in & ~alu_src_in;
  assign addr_mode = mem_to_reg_in | WMemEn_in;
  // Writes to x0 are squashed here so downstream never sees them.
  assign wreg_eff  = WRegEn_in & (WReg1_in != '0);
  assign useful    = wreg_eff | WMemEn_in;

  ex_alu #(
    .WIDTH(PROC_DATA_WIDTH)
  ) u_alu (
    .a        (R1out_in),
    .b        (op_b),
    .func3    (func3_in),
    .func7    (func7_in),
    .sub_en   (sub_en),
    .addr_mode(addr_mode),
    .result   (alu_result)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      alu_result_o       <= '0;
      store_data_o       <= '0;
      WRegEn_o           <= 1'b0;
      WMemEn_o           <= 1'b0;
      mem_to_reg_o       <= 1'b0;
      WReg1_o            <= '0;
      thread_id_o        <= '0;
      pc_carry_baggage_o <= '0;
    end else begin
      alu_result_o       <= alu_result;
      store_data_o       <= R2out_in;
      WRegEn_o           <= wreg_eff;
      WMemEn_o           <= WMemEn_in;
      mem_to_reg_o       <= mem_to_reg_in;
      WReg1_o            <= WReg1_in;
      thread_id_o        <= thread_id_in;
      pc_carry_baggage_o <= pc_carry_baggage_i;
    end
  end

  // Clear has priority over a same-edge increment.
  always_ff @(posedge CLK) begin
    if (RST || cnt_clr_i) begin
      for (int i = 0; i < NUM_THREADS; i++) begin
        cnt_q[i] <= '0;
      end
    end else if (useful) begin
      cnt_q[thread_id_in] <= sat_inc(cnt_q[thread_id_in]);
    end
  end

  // Read port shows the counter as it stood before this edge's update.
  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_rd_data_o <= '0;
    end else begin
      cnt_rd_data_o <= cnt_q[cnt_rd_thread_i];
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
module tb_ex_stage;

  logic        CLK;
  logic        RST;
  logic        WRegEn_in, WMemEn_in, alu_src_in, mem_to_reg_in;
  logic [15:0] R1out_in, R2out_in, sign_ext_in;
  logic [4:0]  WReg1_in;
  logic [2:0]  func3_in;
  logic        func7_in;
  logic [1:0]  thread_id_in;
  logic [7:0]  pc_carry_baggage_i;
  logic [15:0] alu_result_o, store_data_o;
  logic        WRegEn_o, WMemEn_o, mem_to_reg_o;
  logic [4:0]  WReg1_o;
  logic [1:0]  thread_id_o;
  logic [7:0]  pc_carry_baggage_o;
  logic        cnt_clr_i;
  logic [1:0]  cnt_rd_thread_i;
  logic [15:0] cnt_rd_data_o;

  int n_checks;
  int n_errors;

  // Reference model state
  int          cnt_m [4];
  logic [15:0] exp_alu, exp_store, exp_rd;
  logic        exp_wreg, exp_wmem, exp_m2r;
  logic [4:0]  exp_dst;
  logic [1:0]  exp_tid;
  logic [7:0]  exp_bag;

  ex_stage dut (
    .CLK               (CLK),
    .RST               (RST),
    .WRegEn_in         (WRegEn_in),
    .WMemEn_in         (WMemEn_in),
    .alu_src_in        (alu_src_in),
    .mem_to_reg_in     (mem_to_reg_in),
    .R1out_in          (R1out_in),
    .R2out_in          (R2out_in),
    .sign_ext_in       (sign_ext_in),
    .WReg1_in          (WReg1_in),
    .func3_in          (func3_in),
    .func7_in          (func7_in),
    .thread_id_in      (thread_id_in),
    .pc_carry_baggage_i(pc_carry_baggage_i),
    .alu_result_o      (alu_result_o),
    .store_data_o      (store_data_o),
    .WRegEn_o          (WRegEn_o),
    .WMemEn_o          (WMemEn_o),
    .mem_to_reg_o      (mem_to_reg_o),
    .WReg1_o           (WReg1_o),
    .thread_id_o       (thread_id_o),
    .pc_carry_baggage_o(pc_carry_baggage_o),
    .cnt_clr_i         (cnt_clr_i),
    .cnt_rd_thread_i   (cnt_rd_thread_i),
    .cnt_rd_data_o     (cnt_rd_data_o)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Instruction semantics from the ISA description, on plain integers.
  function automatic int ref_alu(int a, int b, int f3, int f7, int src, int addr);
    int sa, sb, sh;
    sa = (a > 32767) ? a - 65536 : a;
    sb = (b > 32767) ? b - 65536 : b;
    sh = b % 16;
    if (addr != 0) return (a + b) % 65536;
    case (f3)
      0: return (f7 != 0 && src == 0) ? (a - b + 65536) % 65536 : (a + b) % 65536;
      1: return (a * (1 << sh)) % 65536;
      2: return (sa < sb) ? 1 : 0;
      3: return (a < b) ? 1 : 0;
      4: return a ^ b;
      5: begin
        if (f7 != 0) begin
          // floor division of the signed value
          if (sa >= 0) return sa / (1 << sh);
          return (65536 + (sa - (1 << sh) + 1) / (1 << sh)) % 65536;
        end
        return a / (1 << sh);
      end
      6: return a | b;
      default: return a & b;
    endcase
  endfunction

  task automatic drive(input logic [2:0] f3, input logic f7, input logic src,
                       input logic m2r, input logic wmem, input logic wreg,
                       input logic [4:0] dst, input logic [15:0] a,
                       input logic [15:0] r2, input logic [15:0] imm,
                       input logic [1:0] tid);
    func3_in = f3; func7_in = f7; alu_src_in = src; mem_to_reg_in = m2r;
    WMemEn_in = wmem; WRegEn_in = wreg; WReg1_in = dst;
    R1out_in = a; R2out_in = r2; sign_ext_in = imm; thread_id_in = tid;
    pc_carry_baggage_i = 8'($urandom);
  endtask

  task automatic bubble(input logic [1:0] tid);
    drive(3'($urandom), 1'($urandom), 1'($urandom), 1'b0, 1'b0, 1'b0,
          5'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), tid);
  endtask

  // Update the model with the inputs presented now, then take one edge.
  task automatic cycle();
    int b, r;
    bit useful;
    if (RST) begin
      exp_alu = '0; exp_store = '0; exp_wreg = 0; exp_wmem = 0; exp_m2r = 0;
      exp_dst = '0; exp_tid = '0; exp_bag = '0; exp_rd = '0;
      for (int i = 0; i < 4; i++) cnt_m[i] = 0;
    end else begin
      b = alu_src_in ? int'(sign_ext_in) : int'(R2out_in);
      r = ref_alu(int'(R1out_in), b, int'(func3_in), int'(func7_in),
                  int'(alu_src_in), int'(mem_to_reg_in | WMemEn_in));
      exp_alu   = 16'(r);
      exp_store = R2out_in;
      exp_wreg  = WRegEn_in && (WReg1_in != 0);
      exp_wmem  = WMemEn_in;
      exp_m2r   = mem_to_reg_in;
      exp_dst   = WReg1_in;
      exp_tid   = thread_id_in;
      exp_bag   = pc_carry_baggage_i;
      exp_rd    = 16'(cnt_m[cnt_rd_thread_i]);
      useful    = exp_wreg || WMemEn_in;
      if (cnt_clr_i) begin
        for (int i = 0; i < 4; i++) cnt_m[i] = 0;
      end else if (useful && cnt_m[thread_id_in] < 65535) begin
        cnt_m[thread_id_in] = cnt_m[thread_id_in] + 1;
      end
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    drive(3'b100, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 5'd7, 16'h1234, 16'h5678, 16'h9ABC, 2'd3);
    cnt_clr_i = 1'b0; cnt_rd_thread_i = 2'd2;
    cycle();
    cycle();
    n_checks++;
    if ({alu_result_o, store_data_o, WRegEn_o, WMemEn_o, mem_to_reg_o, WReg1_o,
         thread_id_o, pc_carry_baggage_o, cnt_rd_data_o} !== '0) begin
      n_errors++;
      $display("FAIL reset_outputs: got alu=%h st=%h wr=%b wm=%b m2r=%b dst=%0d tid=%0d bag=%h rd=%h, required all zero",
               alu_result_o, store_data_o, WRegEn_o, WMemEn_o, mem_to_reg_o, WReg1_o,
               thread_id_o, pc_carry_baggage_o, cnt_rd_data_o);
    end
    RST = 1'b0;
  endtask

  task automatic test_alu_sweep();
    logic [2:0]  f3s  [10] = '{3'b000, 3'b000, 3'b001, 3'b101, 3'b101, 3'b010, 3'b011, 3'b100, 3'b110, 3'b111};
    logic        f7s  [10] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [15:0] exps [10] = '{16'h8004, 16'h7FFE, 16'h0008, 16'h1000, 16'hF000,
                               16'h0001, 16'h0000, 16'h8002, 16'h8003, 16'h0001};
    for (int i = 0; i < 10; i++) begin
      drive(f3s[i], f7s[i], 1'b0, 1'b0, 1'b0, 1'b1, 5'd3, 16'h8001, 16'h0003, 16'h7777, 2'd0);
      cycle();
      n_checks++;
      if (alu_result_o !== exps[i]) begin
        n_errors++;
        $display("FAIL alu_sweep f3=%b f7=%b: got %h, required %h", f3s[i], f7s[i], alu_result_o, exps[i]);
      end
    end
  endtask

  task automatic test_imm_addr();
    drive(3'b000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 5'd4, 16'h0005, 16'h0002, 16'hFFFF, 2'd1);
    cycle();
    n_checks++;
    if (alu_result_o !== 16'h0004) begin
      n_errors++;
      $display("FAIL imm_add_not_sub: got %h, required 0004", alu_result_o);
    end
    n_checks++;
    if (store_data_o !== 16'h0002) begin
      n_errors++;
      $display("FAIL store_data_indep_src: got %h, required 0002", store_data_o);
    end
    drive(3'b100, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 5'd9, 16'h0010, 16'hAAAA, 16'h0004, 2'd2);
    cycle();
    n_checks++;
    if (alu_result_o !== 16'h0014 || mem_to_reg_o !== 1'b1) begin
      n_errors++;
      $display("FAIL load_address: got %h m2r=%b, required 0014 m2r=1", alu_result_o, mem_to_reg_o);
    end
  endtask

  task automatic test_x0_write();
    cnt_clr_i = 1'b1; bubble(2'd0); cycle(); cnt_clr_i = 1'b0;
    drive(3'b110, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 16'h00F0, 16'h000F, 16'h0000, 2'd2);
    cycle();
    n_checks++;
    if (WRegEn_o !== 1'b0 || WReg1_o !== 5'd0 || thread_id_o !== 2'd2 || alu_result_o !== 16'h00FF) begin
      n_errors++;
      $display("FAIL x0_write: got wr=%b dst=%0d tid=%0d alu=%h, required wr=0 dst=0 tid=2 alu=00ff",
               WRegEn_o, WReg1_o, thread_id_o, alu_result_o);
    end
    cnt_rd_thread_i = 2'd2; bubble(2'd2); cycle();
    n_checks++;
    if (cnt_rd_data_o !== 16'd0) begin
      n_errors++;
      $display("FAIL x0_not_counted: got %0d, required 0", cnt_rd_data_o);
    end
  endtask

  task automatic test_counters();
    cnt_rd_thread_i = 2'd0;
    cnt_clr_i = 1'b1; bubble(2'd0); cycle(); cnt_clr_i = 1'b0;
    drive(3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd1, 16'd1, 16'd2, 16'd3, 2'd1); cycle();
    drive(3'b000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 16'd1, 16'd2, 16'd3, 2'd1); cycle();
    drive(3'b111, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd31, 16'd1, 16'd2, 16'd3, 2'd1); cycle();
    n_checks++;
    if (WRegEn_o !== 1'b1 || WMemEn_o !== 1'b0) begin
      n_errors++;
      $display("FAIL useful_forward: got wr=%b wm=%b, required wr=1 wm=0", WRegEn_o, WMemEn_o);
    end
    bubble(2'd1); cycle();
    n_checks++;
    if (WRegEn_o !== 1'b0 || WMemEn_o !== 1'b0 || thread_id_o !== 2'd1) begin
      n_errors++;
      $display("FAIL bubble_forward: got wr=%b wm=%b tid=%0d, required 0 0 1", WRegEn_o, WMemEn_o, thread_id_o);
    end
    cnt_rd_thread_i = 2'd1; bubble(2'd3); cycle();
    n_checks++;
    if (cnt_rd_data_o !== 16'd3) begin
      n_errors++;
      $display("FAIL thread1_count: got %0d, required 3", cnt_rd_data_o);
    end
  endtask

  task automatic test_saturation_clear();
    cnt_rd_thread_i = 2'd0;
    cnt_clr_i = 1'b1; bubble(2'd0); cycle(); cnt_clr_i = 1'b0;
    drive(3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 16'd1, 16'd1, 16'd1, 2'd0);
    for (int i = 0; i < 65535; i++) cycle();
    bubble(2'd0); cycle();
    n_checks++;
    if (cnt_rd_data_o !== 16'hFFFF) begin
      n_errors++;
      $display("FAIL preload_ffff: got %h, required ffff", cnt_rd_data_o);
    end
    drive(3'b000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 16'd1, 16'd1, 16'd1, 2'd0); cycle();
    bubble(2'd0); cycle();
    n_checks++;
    if (cnt_rd_data_o !== 16'hFFFF) begin
      n_errors++;
      $display("FAIL saturate: got %h, required ffff", cnt_rd_data_o);
    end
    cnt_clr_i = 1'b1;
    drive(3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd6, 16'd1, 16'd1, 16'd1, 2'd0); cycle();
    cnt_clr_i = 1'b0;
    bubble(2'd0); cycle();
    n_checks++;
    if (cnt_rd_data_o !== 16'd0) begin
      n_errors++;
      $display("FAIL clear_beats_inc: got %h, required 0000", cnt_rd_data_o);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive(3'($urandom), 1'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 3) == 0), 1'($urandom), 5'($urandom_range(0, 3) == 0 ? 0 : $urandom),
            16'($urandom), 16'($urandom), 16'($urandom), 2'($urandom));
      cnt_clr_i = ($urandom_range(0, 63) == 0);
      cnt_rd_thread_i = 2'($urandom);
      cycle();
      n_checks++;
      if (alu_result_o !== exp_alu || store_data_o !== exp_store) begin
        n_errors++;
        $display("FAIL random_data i=%0d: got alu=%h st=%h, required alu=%h st=%h",
                 i, alu_result_o, store_data_o, exp_alu, exp_store);
      end
      n_checks++;
      if ({WRegEn_o, WMemEn_o, mem_to_reg_o, WReg1_o, thread_id_o, pc_carry_baggage_o} !==
          {exp_wreg, exp_wmem, exp_m2r, exp_dst, exp_tid, exp_bag}) begin
        n_errors++;
        $display("FAIL random_ctrl i=%0d: got %b%b%b dst=%0d tid=%0d bag=%h, required %b%b%b dst=%0d tid=%0d bag=%h",
                 i, WRegEn_o, WMemEn_o, mem_to_reg_o, WReg1_o, thread_id_o, pc_carry_baggage_o,
                 exp_wreg, exp_wmem, exp_m2r, exp_dst, exp_tid, exp_bag);
      end
      n_checks++;
      if (cnt_rd_data_o !== exp_rd) begin
        n_errors++;
        $display("FAIL random_cnt i=%0d: got %0d, required %0d", i, cnt_rd_data_o, exp_rd);
      end
    end
    cnt_clr_i = 1'b0;
  endtask

  task automatic test_reset_midstream();
    drive(3'b110, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd8, 16'hF0F0, 16'h0F0F, 16'h0, 2'd3); cycle();
    RST = 1'b1;
    drive(3'b000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd9, 16'h1111, 16'h2222, 16'h0, 2'd2); cycle();
    RST = 1'b0;
    n_checks++;
    if ({alu_result_o, store_data_o, WRegEn_o, WMemEn_o, mem_to_reg_o, WReg1_o,
         thread_id_o, pc_carry_baggage_o, cnt_rd_data_o} !== '0) begin
      n_errors++;
      $display("FAIL midstream_reset: got alu=%h st=%h wr=%b wm=%b tid=%0d rd=%h, required all zero",
               alu_result_o, store_data_o, WRegEn_o, WMemEn_o, thread_id_o, cnt_rd_data_o);
    end
    drive(3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd10, 16'h0100, 16'h0001, 16'h0, 2'd1); cycle();
    n_checks++;
    if (alu_result_o !== 16'h00FF || WRegEn_o !== 1'b1 || WReg1_o !== 5'd10 || thread_id_o !== 2'd1) begin
      n_errors++;
      $display("FAIL post_reset_first: got alu=%h wr=%b dst=%0d tid=%0d, required 00ff 1 10 1",
               alu_result_o, WRegEn_o, WReg1_o, thread_id_o);
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    RST = 1'b1;
    cnt_clr_i = 1'b0;
    cnt_rd_thread_i = 2'd0;
    bubble(2'd0);
    test_reset();
    test_alu_sweep();
    test_imm_addr();
    test_x0_write();
    test_counters();
    test_random();
    test_saturation_clear();
    test_reset_midstream();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage of the 4-thread barrel pipeline; sits directly downstream of the ID/EX pipeline register and consumes its outputs.
- Computes the ALU result, or the load/store address, from R1/R2/sign-extended immediate, func3 and func7.
- Registers the result plus forwarded control into EX/MEM outputs (1-cycle latency).
- Keeps per-thread saturating counters of useful instructions, readable through a registered debug port.

Parameters:
PROC_DATA_WIDTH, 16, datapath width
PROC_REGFILE_LOG2_DEEP, 5, register-index width
INSTMEM_LOG2_DEEP, 8, PC baggage width
NUM_THREADS, 4, hardware threads; thread id width is log2(NUM_THREADS)=2

Ports:
CLK  in  1  clock, rising edge
RST  in  1  synchronous reset, active-high
WRegEn_in  in  1  register write enable from ID/EX
WMemEn_in  in  1  memory write (store) from ID/EX
alu_src_in  in  1  1 = operand B is sign_ext_in, 0 = R2out_in
mem_to_reg_in  in  1  load
R1out_in  in  PROC_DATA_WIDTH  operand A
R2out_in  in  PROC_DATA_WIDTH  operand B / store data
sign_ext_in  in  PROC_DATA_WIDTH  immediate
WReg1_in  in  PROC_REGFILE_LOG2_DEEP  destination register
func3_in  in  3  ALU op
func7_in  in  1  op modifier (sub / arithmetic shift)
thread_id_in  in  2  thread tag
pc_carry_baggage_i  in  INSTMEM_LOG2_DEEP  PC baggage
alu_result_o  out  PROC_DATA_WIDTH  ALU result or memory address
store_data_o  out  PROC_DATA_WIDTH  registered R2out_in
WRegEn_o, WMemEn_o, mem_to_reg_o  out  1 each  forwarded control
WReg1_o  out  PROC_REGFILE_LOG2_DEEP  forwarded destination
thread_id_o  out  2  forwarded thread tag
pc_carry_baggage_o  out  INSTMEM_LOG2_DEEP  forwarded baggage
cnt_clr_i  in  1  clear all counters
cnt_rd_thread_i  in  2  counter select
cnt_rd_data_o  out  16  selected counter value, registered

Behaviour:
- Reset: synchronous, active-high. On RST=1 at the clock edge, every output register and every counter becomes 0.
- Latency: inputs sampled at edge N appear on outputs after edge N. No stalls and no backpressure; one instruction per cycle, threads interleaved by upstream.
- Operand B = alu_src_in ? sign_ext_in : R2out_in.
- Address mode: if mem_to_reg_in=1 or WMemEn_in=1, result = A+B (mod 2^16), regardless of func3/func7.
- Otherwise, result by func3:
  - 000: add, or sub when func7=1 and alu_src=0. With alu_src=1, func7 is ignored and the op is always add.
  - 001: sll by B[3:0].
  - 010: slt, signed; result 1 or 0.
  - 011: sltu, unsigned; result 1 or 0.
  - 100: xor.
  - 101: srl, or sra when func7=1; shift amount B[3:0].
  - 110: or.
  - 111: and.
- Add/sub wraps; no overflow flag.
- x0 protection: if WReg1_in==0, WRegEn_o is registered as 0. The other fields still pass through unchanged.
- store_data_o is always the registered R2out_in, independent of alu_src.
- Bubble: WRegEn_in=0 and WMemEn_in=0 (after x0 masking) is a bubble. A bubble still propagates all fields and is not counted.
- Counters: one 16-bit counter per thread.
  - Increment the counter of thread_id_in when the instruction is useful: effective WRegEn (after x0 masking) or WMemEn_in.
  - Saturate at 0xFFFF (stay at 0xFFFF, no wrap).
  - cnt_clr_i=1 zeroes all counters on that edge. Clear beats a simultaneous increment: result 0, not 1.
- Counter read: cnt_rd_data_o <= counter[cnt_rd_thread_i], registered, 1-cycle latency. The value shown is the pre-update value for that edge, so an increment on edge N is visible after edge N+1.
- Reset mid-stream: all in-flight output state is discarded; the first valid instruction after RST deasserts appears one cycle later.

Decomposition:
- Shared package holds:
  - ALU func3 encodings (ALU_ADD=3'b000 … ALU_AND=3'b111).
  - NUM_THREADS and the thread id width.
  - COUNTER_WIDTH=16.
- One combinational sub-module, ex_alu: inputs a, b, func3, func7, sub_en, addr_mode; output result.
- ex_stage instantiates ex_alu and holds the EX/MEM registers, the counter array and the read register.

Test Plan:
- ALU sweep: A=0x8001, B=0x0003 (R-type).
  - func3 000/func7=0 -> 0x8004; 000/func7=1 -> 0x7FFE.
  - 001 -> 0x0008; 101/func7=0 -> 0x1000; 101/func7=1 -> 0xF000.
  - 010 -> 0x0001; 011 -> 0x0000.
- Immediate and address mode:
  - alu_src=1, func7=1, func3=000, A=5, imm=0xFFFF -> 0x0004 (add, not sub).
  - mem_to_reg=1, func3=100, A=0x0010, imm=4 -> 0x0014.
- x0 write: WRegEn_in=1, WReg1_in=0, thread 2 -> WRegEn_o=0, thread-2 counter unchanged.
- Counters: 3 useful thread-1 instructions plus 1 bubble; then read thread 1 -> cnt_rd_data_o=3, 1 cycle after select.
- Saturation and clear:
  - Preload thread 0 to 0xFFFF with 65535 increments; one more -> still 0xFFFF.
  - cnt_clr_i coincident with an increment -> 0.
- Reset: assert RST for one cycle mid-stream -> all outputs 0 next cycle; the following instruction's result appears exactly 1 cycle after its input.
